// File: rtl/mux8_bus_arbiter.sv
// mux8_bus_arbiter: round-robin arbiter for an 8-input, 32-bit shared-bus mux.
// Drives the one-hot grant and the mux select lines s2..s0, and bounds every
// tenure to MAX_BURST accepted beats so that no requester can starve the others.
module mux8_bus_arbiter #(
   parameter int unsigned MAX_BURST = 4,
   parameter int unsigned CNT_W     = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic       ready,
   output logic [7:0] gnt,
   output logic       s0,
   output logic       s1,
   output logic       s2,
   output logic       bus_valid,
   output logic       owner_last
);

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   state_t           state;
   logic [2:0]       sel;
   logic [2:0]       ptr;
   logic [CNT_W-1:0] beat_cnt;

   logic             at_limit;
   logic             accept;
   logic             rel_drop;
   logic             rel_burst;
   logic             release_now;
   logic [7:0]       arb_mask;
   logic [2:0]       arb_start;
   logic             win_found;
   logic [2:0]       win_idx;

   // First set bit of mask at or after start, wrapping modulo 8.
   function automatic logic [3:0] pick(input logic [7:0] mask, input logic [2:0] start);
      logic [3:0] r;
      logic [2:0] idx;
      r = '0;
      for (int unsigned k = 0; k < 8; k++) begin
         idx = start + 3'(k);
         if (!r[3] && mask[idx]) r = {1'b1, idx};
      end
      return r;
   endfunction

   assign {s2, s1, s0} = sel;

   // Beat handshake, burst-limit detection and release decision for the current owner.
   always_comb begin
      bus_valid   = (state == BUSY) && req[sel];
      at_limit    = (beat_cnt == CNT_W'(MAX_BURST - 1));
      owner_last  = bus_valid && at_limit;
      accept      = bus_valid && ready;
      rel_drop    = (state == BUSY) && !req[sel];
      rel_burst   = accept && at_limit;
      release_now = rel_drop || rel_burst;
   end

   // Arbitration request: from ptr when idle, from owner+1 on release; a dropped
   // owner is masked out so it cannot immediately win its own handover.
   always_comb begin
      arb_mask  = req;
      arb_start = ptr;
      if (state == BUSY) begin
         arb_start = sel + 3'd1;
         if (rel_drop) arb_mask = req & ~gnt;
      end
      {win_found, win_idx} = pick(arb_mask, arb_start);
   end

   // Tenure state machine; grant and select always load on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         gnt      <= '0;
         sel      <= '0;
         ptr      <= '0;
         beat_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (win_found) begin
                  gnt      <= 8'b1 << win_idx;
                  sel      <= win_idx;
                  beat_cnt <= '0;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               if (release_now) begin
                  ptr <= sel + 3'd1;
                  if (win_found) begin
                     gnt      <= 8'b1 << win_idx;
                     sel      <= win_idx;
                     beat_cnt <= '0;
                  end else begin
                     gnt   <= '0;
                     state <= IDLE;
                  end
               end else if (accept) begin
                  beat_cnt <= beat_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               gnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: doc/mux8_bus_arbiter.md
Name: mux8_bus_arbiter

Overview:
- Round-robin arbiter that shares one 8-input, 32-bit shared-bus mux between 8 requesters.
- Drives the mux select lines s0/s1/s2 and one-hot grants.
- Bounds each tenure to MAX_BURST accepted beats, so no requester can starve the others.
- Sits between the requesting units and the shared-bus mux; the sink side handshakes via ready.

Parameters:
- MAX_BURST, 4, maximum accepted beats per grant tenure (legal range 1..7).
- CNT_W, 3, width of the internal beat counter; must hold MAX_BURST-1.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  8  per-requester request; req[i] held high while requester i has beats to send
- ready  input  1  sink accepts the current beat this cycle
- gnt  output  8  one-hot grant, registered; all-zero when bus idle
- s0  output  1  mux select bit 0 (LSB), registered
- s1  output  1  mux select bit 1, registered
- s2  output  1  mux select bit 2 (MSB), registered
- bus_valid  output  1  current beat on the mux output is valid
- owner_last  output  1  high during the beat that, if accepted, ends the tenure on burst limit

Behaviour:
- Reset (rst=1 at posedge):
  - gnt=0, s0=s1=s2=0, state=IDLE, ptr=0, beat_cnt=0.
  - bus_valid=0 and owner_last=0 (both combinational from reset state).
  - Reset mid-tenure abandons the burst; no partial-state carryover.
- States: IDLE, BUSY. owner = index of the set gnt bit; {s2,s1,s0} = owner in BUSY.
- Arbitration function pick(mask, ptr):
  - Returns the first i in ptr, ptr+1, ..., ptr+7 (mod 8) with mask[i]=1.
  - Result none if mask=0.
- IDLE:
  - If req!=0, at the edge: gnt=onehot(pick(req,ptr)), sel=that index, beat_cnt=0, state=BUSY.
  - Latency: req rise to gnt high is 1 cycle.
  - If req=0, stay in IDLE; s0..s2 hold their last value to avoid mux toggling; gnt=0.
- BUSY:
  - bus_valid = req[owner]. Combinational; an owner dropping req stops valid in the same cycle.
  - Beat accepted when bus_valid && ready; beat_cnt increments on each accepted beat.
  - owner_last = bus_valid && (beat_cnt==MAX_BURST-1).
  - Release conditions, evaluated at the edge:
    - (a) req[owner]=0, or
    - (b) accepted beat with beat_cnt==MAX_BURST-1.
  - On release:
    - ptr=(owner+1) mod 8.
    - Re-arbitrate in the same edge with pick(req_next, owner+1), where req_next = req with bit owner cleared for case (a) and unmodified for case (b).
    - Any winner: gnt/sel load directly, beat_cnt=0, remain BUSY. This gives zero-bubble handover.
    - No winner: state=IDLE, gnt=0.
  - Sole requester hitting burst limit with req still high: it is re-granted back-to-back, beat_cnt reset.
  - ready low: stall; beat_cnt, gnt, sel unchanged; no timeout.
  - Requests from non-owners never affect the current tenure.
- gnt and {s2,s1,s0} always change on the same edge; gnt is never multi-hot.

Test Plan:
- Reset then req=8'h00 for 5 cycles -> gnt=0, bus_valid=0, s2s1s0=000 throughout.
- req=8'h24 (bits 2,5) from ptr=0, ready=1, MAX_BURST=4:
  - Cycle after req: gnt=8'h04, sel=010.
  - 4 beats later: gnt=8'h20, sel=101 with no idle cycle.
  - After 4 more beats: gnt=8'h04 again.
- req=8'h80 only, ready=1, held 10 cycles:
  - gnt=8'h80, sel=111 continuously.
  - owner_last pulses every 4th beat; beat_cnt restarts each time.
- Owner 3 granted, ready=0 for 6 cycles:
  - gnt stays 8'h08 and beat_cnt stays 0.
  - Then ready=1: exactly 4 beats accepted before release.
- Owner 1 drops req after 2 beats while req[6]=1:
  - bus_valid=0 that cycle.
  - Next cycle gnt=8'h40, sel=110.
- rst asserted mid-burst (owner 5, beat_cnt=2) -> next cycle gnt=0, s2s1s0=000, bus_valid=0; with req[2]=1 and req[5]=1, the following grant goes to 2 (ptr=0).
